// File: rtl/duty_cycle_meter.sv
// Multi-channel duty-cycle meter: counts clock-sampled high cycles per channel
// over a 2^WIDTH-1 cycle window, in continuous or single-shot mode.
module duty_cycle_meter #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      enable_i,
    input  logic                      single_shot_i,
    input  logic                      start_i,
    input  logic [CHANNELS-1:0]       ring_in_i,
    output logic [CHANNELS*WIDTH-1:0] value_o,
    output logic                      valid_o,
    output logic                      busy_o,
    output logic [CHANNELS-1:0]       stuck_hi_o,
    output logic [CHANNELS-1:0]       stuck_lo_o
);

    typedef enum logic {IDLE, MEASURE} state_t;

    localparam logic [WIDTH-1:0] WINDOW = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] LAST   = WINDOW - WIDTH'(1);

    state_t                           state_q;
    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
    logic [WIDTH-1:0]                 win_q;
    logic [CHANNELS-1:0][WIDTH-1:0]   high_q;
    logic [CHANNELS-1:0][WIDTH-1:0]   sum_d;
    logic [CHANNELS*WIDTH-1:0]        value_q;
    logic                             valid_q;
    logic                             busy_q;
    logic [CHANNELS-1:0]              stuck_hi_q;
    logic [CHANNELS-1:0]              stuck_lo_q;
    logic [CHANNELS-1:0]              samp;

    assign samp = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (reset_i) sync_q <= '0;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], ring_in_i};
    end

    // Count including the current sample; used both mid-window and at the end.
    always_comb begin
        sum_d = '0;
        for (int c = 0; c < CHANNELS; c++)
            sum_d[c] = high_q[c] + WIDTH'(samp[c]);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            win_q      <= '0;
            high_q     <= '0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            stuck_hi_q <= '0;
            stuck_lo_q <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable_i && (!single_shot_i || start_i)) begin
                        state_q <= MEASURE;
                        busy_q  <= 1'b1;
                        win_q   <= '0;
                        high_q  <= '0;
                    end
                end
                MEASURE: begin
                    if (!enable_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        win_q   <= '0;
                        high_q  <= '0;
                    end else if (win_q == LAST) begin
                        for (int c = 0; c < CHANNELS; c++) begin
                            value_q[c*WIDTH +: WIDTH] <= sum_d[c];
                            stuck_hi_q[c]             <= (sum_d[c] == WINDOW);
                            stuck_lo_q[c]             <= (sum_d[c] == '0);
                        end
                        valid_q <= 1'b1;
                        win_q   <= '0;
                        high_q  <= '0;
                        if (single_shot_i) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        win_q  <= win_q + WIDTH'(1);
                        high_q <= sum_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign value_o    = value_q;
    assign valid_o    = valid_q;
    assign busy_o     = busy_q;
    assign stuck_hi_o = stuck_hi_q;
    assign stuck_lo_o = stuck_lo_q;

endmodule

// File: tb/tb_duty_cycle_meter.sv
// Directed bench for duty_cycle_meter: default 4x8 instance plus a 1x4 instance.
module tb_duty_cycle_meter;

    logic        clk = 1'b0;
    logic        reset, enable, single_shot, start;
    logic [3:0]  ring_drv;
    logic        sq_en = 1'b0;
    logic        sq_bit = 1'b0;
    logic [3:0]  ring;
    logic [31:0] value;
    logic        valid, busy;
    logic [3:0]  stuck_hi, stuck_lo;

    logic        enable2, ring2;
    logic [3:0]  value2;
    logic        valid2, busy2;
    logic [0:0]  stuck_hi2, stuck_lo2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // ch3 optionally toggles every clock on top of its static level
    always @(posedge clk) #1 sq_bit = sq_en ? ~sq_bit : 1'b0;
    assign ring = {ring_drv[3] ^ sq_bit, ring_drv[2:0]};

    duty_cycle_meter #(.CHANNELS(4), .WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .single_shot_i(single_shot),
        .start_i(start), .ring_in_i(ring), .value_o(value), .valid_o(valid),
        .busy_o(busy), .stuck_hi_o(stuck_hi), .stuck_lo_o(stuck_lo)
    );

    duty_cycle_meter #(.CHANNELS(1), .WIDTH(4), .SYNC_STAGES(2)) dut2 (
        .clk_i(clk), .reset_i(reset), .enable_i(enable2), .single_shot_i(1'b0),
        .start_i(1'b0), .ring_in_i(ring2), .value_o(value2), .valid_o(valid2),
        .busy_o(busy2), .stuck_hi_o(stuck_hi2), .stuck_lo_o(stuck_lo2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Steps until the selected instance shows valid, or the bound runs out.
    task automatic wait_v(input bit which, input int maxc, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!(which ? valid2 : valid) && n < maxc);
    endtask

    initial begin
        int n, bcnt, vcnt, first;
        reset = 1'b1; enable = 1'b0; single_shot = 1'b0; start = 1'b0;
        ring_drv = 4'h0; enable2 = 1'b0; ring2 = 1'b1;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            enable = 1'($urandom); single_shot = 1'($urandom);
            start = 1'($urandom); ring_drv = 4'($urandom);
            step(1);
        end
        check("rst_value", value, 0);
        check("rst_flags", {valid, busy, stuck_hi, stuck_lo}, 0);
        reset = 1'b0; enable = 1'b0; start = 1'b0; single_shot = 1'b0;
        bcnt = 0; vcnt = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (busy) bcnt++;
            if (valid) vcnt++;
        end
        check("idle_busy", bcnt, 0);
        check("idle_valid", vcnt, 0);

        // Continuous mode: ch0 high, ch1 low, ch3 square wave, ch2 pulsed
        ring_drv = 4'b0001; sq_en = 1'b1;
        step(3);
        enable = 1'b1;
        wait_v(0, 300, n);
        check("cont_first_valid", valid, 1);
        ring_drv[2] = 1'b1;
        step(100);
        ring_drv[2] = 1'b0;
        wait_v(0, 300, n);
        check("cont_period1", 100 + n, 255);
        check("cont_ch0", value[7:0], 255);
        check("cont_ch1", value[15:8], 0);
        check("cont_ch2", value[23:16], 100);
        check("cont_sq_ch3", (value[31:24] == 8'd127 || value[31:24] == 8'd128), 1);
        check("cont_stuck_hi", stuck_hi, 4'b0001);
        check("cont_stuck_lo", stuck_lo, 4'b0010);
        step(1);
        check("cont_valid_1cyc", valid, 0);
        check("cont_busy", busy, 1);
        wait_v(0, 300, n);
        check("cont_period2", n + 1, 255);
        check("cont2_ch2", value[23:16], 0);
        check("cont2_sq_ch3", (value[31:24] == 8'd127 || value[31:24] == 8'd128), 1);

        // Single-shot: one start, a start during busy is ignored
        sq_en = 1'b0; enable = 1'b0; single_shot = 1'b1;
        step(3);
        enable = 1'b1;
        step(2);
        check("ss_no_start_busy", busy, 0);
        start = 1'b1;
        bcnt = 0; vcnt = 0; first = 0;
        for (int i = 1; i <= 300; i++) begin
            step(1);
            if (i == 1 || i == 51) start = 1'b0;
            if (i == 50) start = 1'b1;
            if (busy) bcnt++;
            if (valid) begin
                vcnt++;
                if (first == 0) first = i;
            end
        end
        check("ss_valid_at", first, 256);
        check("ss_valid_cnt", vcnt, 1);
        check("ss_busy_cnt", bcnt, 255);
        check("ss_value", value, 32'h0000_00FF);
        check("ss_stuck", {stuck_hi, stuck_lo}, {4'b0001, 4'b1110});

        // Single-shot: start on the valid cycle chains a second window
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_v(0, 300, n);
        check("ss2_first_len", n, 255);
        check("ss2_busy_falls", busy, 0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("ss2_rebusy", busy, 1);
        wait_v(0, 300, n);
        check("ss2_second_len", n, 255);

        // Abort at window cycle 100, then a full window after re-enable
        ring_drv = 4'b1010; single_shot = 1'b0;
        step(100);
        enable = 1'b0;
        step(1);
        check("abort_busy", busy, 0);
        vcnt = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (valid) vcnt++;
        end
        check("abort_no_valid", vcnt, 0);
        check("abort_value_held", value, 32'h0000_00FF);
        enable = 1'b1;
        wait_v(0, 300, n);
        check("reen_len", n, 256);
        check("reen_value", value, 32'hFF00_FF00);
        check("reen_stuck", {stuck_hi, stuck_lo}, {4'b1010, 4'b0101});

        // Reset coinciding with the last sample of a window
        step(254);
        reset = 1'b1;
        step(1);
        check("rst_last_valid", valid, 0);
        check("rst_last_outs", {value, busy, stuck_hi, stuck_lo}, 0);
        enable = 1'b0;
        step(1);
        reset = 1'b0;
        step(1);
        check("rst_last_after", {valid, busy}, 0);

        // Narrow instance: 15-cycle window
        enable2 = 1'b1;
        wait_v(1, 40, n);
        wait_v(1, 40, n);
        check("p2_period", n, 15);
        check("p2_value", value2, 15);
        check("p2_stuck", {stuck_hi2, stuck_lo2}, 2'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
